// File: rtl/eth_ifg_pacer.sv
// eth_ifg_pacer: AXI-Stream frame pacer with a registered 2-entry skid stage, line-rate idle
// enforcement after each frame and frame/error counters. Define ETH_PACER_DIC_EN for deficit idle count.
module eth_ifg_pacer #(
    parameter int DATA_W     = 64,
    parameter int MAX_PKT    = 10,
    parameter int N_PREAMBLE = 8,
    parameter int N_IFG      = 12,
    parameter int CNT_W      = 16
) (
    input  logic                clk156,
    input  logic                cold_reset_n,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tuser,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                gap_active,
    output logic                done
);
    localparam int BYTES = DATA_W / 8;
    localparam int NEED  = N_PREAMBLE + N_IFG;
    localparam int GW    = $clog2(NEED + BYTES) + 1;

    typedef enum logic [1:0] {PASS, GAP, DONE} state_t;

    state_t              state;
    logic [GW-1:0]       gap_cnt;
    logic [GW-1:0]       gap_calc;
    logic                skid_valid;
    logic [DATA_W-1:0]   skid_data;
    logic [BYTES-1:0]    skid_keep;
    logic                skid_last;
    logic                skid_user;
    logic                s_hs;
    logic                stall;
    logic                skid_valid_n;
    logic                frame_end;
    logic                limit_hit;
    logic                pass_next;
    logic [CNT_W-1:0]    frame_cnt_inc;
    int                  k;
    int                  excess;

    function automatic int popcount(input logic [BYTES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < BYTES; i++) n = n + int'(v[i]);
        return n;
    endfunction

`ifdef ETH_PACER_DIC_EN
    localparam int RW = $clog2(BYTES) + 2;
    logic signed [RW-1:0] residue;
    int                   residue_n;

    // Round the idle beats to nearest and carry the signed byte residue into the next frame.
    always_comb begin
        k      = popcount(s_axis_tkeep);
        excess = NEED + int'(residue) - (BYTES - k);
        if (excess <= 0) begin
            gap_calc  = '0;
            residue_n = (excess < 1 - BYTES) ? 1 - BYTES : excess;
        end else begin
            gap_calc  = GW'((excess + BYTES / 2) / BYTES);
            residue_n = excess - ((excess + BYTES / 2) / BYTES) * BYTES;
        end
    end

    always_ff @(posedge clk156 or negedge cold_reset_n) begin
        if (!cold_reset_n) residue <= '0;
        else if (frame_end) residue <= RW'(residue_n);
    end
`else
    always_comb begin
        k        = popcount(s_axis_tkeep);
        excess   = NEED - (BYTES - k);
        gap_calc = (excess <= 0) ? '0 : GW'((excess + BYTES - 1) / BYTES);
    end
`endif

    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign frame_end     = s_hs & s_axis_tlast;
    assign stall         = m_axis_tvalid & ~m_axis_tready;
    assign skid_valid_n  = stall & (skid_valid | s_hs);
    assign frame_cnt_inc = (&frame_cnt) ? frame_cnt : frame_cnt + CNT_W'(1);
    assign limit_hit     = (MAX_PKT != 0) && frame_end && (int'(frame_cnt_inc) == MAX_PKT);
    assign pass_next     = (state == PASS && !(frame_end && (limit_hit || gap_calc != '0)))
                        || (state == GAP && gap_cnt == GW'(1));

    // Ready is registered, so it only opens when the skid entry is guaranteed free next cycle.
    always_ff @(posedge clk156 or negedge cold_reset_n) begin
        if (!cold_reset_n) begin
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_keep     <= '0;
            skid_last     <= 1'b0;
            skid_user     <= 1'b0;
        end else begin
            s_axis_tready <= ~skid_valid_n & pass_next;
            skid_valid    <= skid_valid_n;
            if (!stall) begin
                if (skid_valid) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= skid_data;
                    m_axis_tkeep  <= skid_keep;
                    m_axis_tlast  <= skid_last;
                    m_axis_tuser  <= skid_user;
                end else begin
                    m_axis_tvalid <= s_hs;
                    if (s_hs) begin
                        m_axis_tdata <= s_axis_tdata;
                        m_axis_tkeep <= s_axis_tkeep;
                        m_axis_tlast <= s_axis_tlast;
                        m_axis_tuser <= s_axis_tuser;
                    end
                end
            end else if (s_hs) begin
                skid_data <= s_axis_tdata;
                skid_keep <= s_axis_tkeep;
                skid_last <= s_axis_tlast;
                skid_user <= s_axis_tuser;
            end
        end
    end

    // Gap counts input-side cycles only; output backpressure never stretches it.
    always_ff @(posedge clk156 or negedge cold_reset_n) begin
        if (!cold_reset_n) begin
            state      <= PASS;
            gap_cnt    <= '0;
            gap_active <= 1'b0;
            done       <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            if (frame_end) begin
                frame_cnt <= frame_cnt_inc;
                if (s_axis_tuser && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
            end
            case (state)
                PASS: begin
                    if (limit_hit) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (frame_end && gap_calc != '0) begin
                        state      <= GAP;
                        gap_cnt    <= gap_calc;
                        gap_active <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(1)) begin
                        state      <= PASS;
                        gap_active <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                DONE:    done  <= 1'b1;
                default: state <= PASS;
            endcase
        end
    end
endmodule

// File: doc/eth_ifg_pacer.md
Name: eth_ifg_pacer

Overview:
- Parametrised AXI-Stream frame pacer between a DUT's TX stream and the simulated PHY/line model.
- Forwards frames beat-for-beat through a registered 2-entry skid stage.
- After each frame, enforces line-rate idle time (preamble + inter-frame gap) computed from last-beat occupancy.
- Counts frames and error frames; stops accepting after a configurable frame limit.

Parameters:
- DATA_W, 64, stream data width in bits; multiple of 8, 32..512; BYTES = DATA_W/8.
- MAX_PKT, 10, frame limit; 0 = unlimited.
- N_PREAMBLE, 8, preamble+SFD bytes charged per frame.
- N_IFG, 12, inter-frame gap bytes charged per frame.
- CNT_W, 16, width of frame/error counters.

Ports:
- clk156  in  1  sole clock.
- cold_reset_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  DATA_W  input data.
- s_axis_tkeep  in  BYTES  byte enables; contiguous from bit 0; all-ones except on tlast.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  frame error flag; sampled on tlast beat.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  DATA_W  output data.
- m_axis_tkeep  out  BYTES  output byte enables.
- m_axis_tlast  out  1  output last.
- m_axis_tuser  out  1  output error flag.
- frame_cnt  out  CNT_W  frames accepted (tlast handshakes on s side).
- err_cnt  out  CNT_W  accepted frames with tuser=1 on tlast.
- gap_active  out  1  high while the idle gap is being enforced.
- done  out  1  frame limit reached.

Behaviour:
- Reset (async assert, sync deassert by consumer): all m_axis_* = 0, s_axis_tready = 0 in reset; skid empty; counters = 0; gap_active = 0; done = 0; state = PASS.
- Skid stage:
  - Latency 1 cycle s→m when the output is not stalled.
  - s_axis_tready = (skid has a free entry) & state==PASS, registered.
  - Full throughput under continuous m_axis_tready.
  - No beat is dropped, duplicated or reordered.
- States:
  - PASS: accepting beats. On tlast handshake, compute GAP. If GAP>0, go to GAP; otherwise stay in PASS. If MAX_PKT reached, go to DONE (takes priority).
  - GAP: s_axis_tready=0; gap_active=1; down-counter loaded with GAP and decremented each cycle. At 1, return to PASS next cycle. The first beat of the next frame can therefore be accepted exactly GAP cycles after the tlast handshake cycle +1.
  - DONE: s_axis_tready=0 permanently until reset; done=1; the skid drains normally to m side.
- Gap arithmetic:
  - k = popcount(tkeep on last beat).
  - slack = BYTES−k.
  - need = N_PREAMBLE+N_IFG.
  - GAP = 0 if need≤slack, else ceil((need−slack)/BYTES).
  - Compute at elaboration-friendly width ($clog2(need+BYTES)+1).
- Counters:
  - frame_cnt increments on every s-side tlast handshake.
  - err_cnt increments when that beat also has tuser=1.
  - Both saturate at all-ones.
- Frame limit: with MAX_PKT≠0, the frame_cnt==MAX_PKT transition enters DONE in the same cycle the counter updates. Gap is not enforced.
- Backpressure: m_axis_tready low during GAP does not extend or shorten the gap; the gap counts cycles on the input side only.
- Reset mid-frame: partial frame is discarded; m_axis_tvalid drops immediately; counters clear.
- tkeep=0 on a tlast beat is treated as k=0; it is forwarded unchanged.

Optional Feature:
- ETH_PACER_DIC_EN: deficit idle count.
  - Defined: the gap is rounded to the nearest beat instead of up, and the rounding residue (0..BYTES−1 bytes, signed) is carried into the next frame's need. Average idle over many frames equals need bytes exactly.
  - Residue resets to 0 on reset.
  - Undefined: plain ceil rounding; no carry state.

Test Plan:
- DATA_W=64, need=20, frame of 3 beats with last tkeep=0xFF → GAP=3; next frame first beat accepted 4 cycles after tlast handshake; frame_cnt=1.
- Last tkeep=0x0F → slack 4, GAP=2. Last tkeep=0x01 → slack 7, GAP=2.
- N_PREAMBLE=0, N_IFG=0 → back-to-back frames; s_axis_tready never deasserts; gap_active stays 0.
- MAX_PKT=2, send 3 frames → done=1 after the 2nd tlast; 3rd frame never accepted; frame_cnt=2; m side outputs exactly 2 frames.
- Random m_axis_tready (50%) over 100 frames → output beat sequence identical to input; err_cnt equals the injected tuser count (e.g. 7).
- Assert cold_reset_n low mid-frame → next cycle: m_axis_tvalid=0, counters=0, done=0; a new frame after release passes intact.
